// File: rtl/gray_bcd_conv_seq_if.sv
// Valid/ready request and response channels of the BCD <-> Gray converter.
// The producer/consumer side uses master; the converter uses slave.
interface gray_bcd_conv_seq_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/gray_bcd_conv_seq.sv
// Iterative packed-BCD <-> Gray converter sharing one shift/add-3 datapath:
// double-dabble for Gray->BCD, reverse double-dabble for BCD->Gray.
module gray_bcd_conv_seq #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_bcd_conv_seq_if.slave   bus
);

  localparam int unsigned DW  = 4 * DIGITS;
  localparam int unsigned SRW = DW + BIN_W;
  localparam int unsigned CW  = $clog2(BIN_W + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

  generate
    if ((BIN_W > DW) || (BIN_W >= 64) || ((64'd1 << BIN_W) <= MAX_VAL)) begin : g_bad_params
      $error("gray_bcd_conv_seq: illegal DIGITS/BIN_W combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            mode_q;
  logic            err_q;
  logic [SRW-1:0]  sr_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic            out_err_q;

  logic [BIN_W-1:0] load_bin;
  logic             load_err;
  logic [SRW-1:0]   sr_d;
  logic [BIN_W-1:0] step_bin;
  logic [DW-1:0]    out_data_d;

  // Gray -> binary by prefix XOR from the MSB, plus accept-time range checks.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    load_bin = '0;
    for (int unsigned j = 0; j < BIN_W; j++) begin
      acc                  = acc ^ bus.in_data[BIN_W-1-j];
      load_bin[BIN_W-1-j]  = acc;
    end
    load_err = 1'b0;
    if (bus.in_mode) begin
      if ((bus.in_data >> BIN_W) != '0) load_err = 1'b1;
      if (64'(load_bin) > MAX_VAL)      load_err = 1'b1;
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (bus.in_data[4*i +: 4] > 4'd9) load_err = 1'b1;
      end
    end
  end

  // One iteration; {bcd, bin} live in a single shift register with bin in the LSBs.
  always_comb begin
    logic [SRW-1:0] v;
    v = sr_q;
    if (mode_q) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (v[BIN_W+4*i +: 4] >= 4'd5) v[BIN_W+4*i +: 4] = v[BIN_W+4*i +: 4] + 4'd3;
      end
      v = v << 1;
    end else begin
      v = v >> 1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (v[BIN_W+4*i +: 4] >= 4'd8) v[BIN_W+4*i +: 4] = v[BIN_W+4*i +: 4] - 4'd3;
      end
    end
    sr_d = v;
  end

  always_comb begin
    step_bin = sr_d[BIN_W-1:0];
    if (mode_q) out_data_d = err_q ? {DIGITS{4'h9}} : sr_d[SRW-1:BIN_W];
    else        out_data_d = err_q ? '0 : DW'(step_bin ^ (step_bin >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      sr_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            state_q    <= S_CONV;
            in_ready_q <= 1'b0;
            mode_q     <= bus.in_mode;
            err_q      <= load_err;
            cnt_q      <= '0;
            sr_q       <= bus.in_mode ? {{DW{1'b0}}, load_bin}
                                      : {bus.in_data, {BIN_W{1'b0}}};
          end
        end
        S_CONV: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_W - 1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_err_q   <= err_q;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_gray_bcd_conv_seq.sv
// Self-checking bench for gray_bcd_conv_seq (DIGITS=2, BIN_W=7): directed
// cases, backpressure, mid-conversion reset, random traffic and round trips.
module tb_gray_bcd_conv_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  gray_bcd_conv_seq_if #(.DW(8)) bus ();

  gray_bcd_conv_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain decimal/Gray arithmetic.
  task automatic model(input bit mode, input logic [7:0] d, output logic [7:0] ed, output bit ee);
    int v;
    int g;
    if (mode) begin
      g = int'(d) & 127;
      v = 0;
      for (int s = 0; s < 7; s++) v = v ^ (g >> s);
      if (d > 8'd127 || v > 99) begin
        ed = 8'h99; ee = 1'b1;
      end else begin
        ed = 8'(((v / 10) << 4) | (v % 10)); ee = 1'b0;
      end
    end else begin
      if (d[7:4] > 4'd9 || d[3:0] > 4'd9) begin
        ed = 8'h00; ee = 1'b1;
      end else begin
        v  = int'(d[7:4]) * 10 + int'(d[3:0]);
        ed = 8'(v ^ (v >> 1)); ee = 1'b0;
      end
    end
  endtask

  task automatic send(input string tag, input bit mode, input logic [7:0] d);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_mode  = 1'($urandom);
    bus.in_data  = 8'($urandom);
  endtask

  // Called right after the accept edge; counts edges until out_valid is seen.
  task automatic wait_out(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.out_valid && n < 40);
    check({tag, ":latency"}, 32'(n), 32'd7);
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, ":vld_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, ":rdy_rise"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_req(input string tag, input bit mode, input logic [7:0] d,
                        input logic [7:0] ed, input bit ee, input int stall,
                        output logic [7:0] got);
    send(tag, mode, d);
    wait_out(tag);
    check({tag, ":data"}, 32'(bus.out_data), 32'(ed));
    check({tag, ":err"},  32'(bus.out_err),  32'(ee));
    got = bus.out_data;
    repeat (stall) @(negedge clk);
    take(tag);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] got2;
    logic [7:0] ed;
    logic [7:0] bcd;
    bit         ee;
    bit         md;
    logic [7:0] d;
    bit         stale;

    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst:in_ready",  32'(bus.in_ready),  32'd1);
    check("rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("rst:out_data",  32'(bus.out_data),  32'd0);
    check("rst:out_err",   32'(bus.out_err),   32'd0);

    do_req("g2b_57",  1'b1, 8'h25, 8'h57, 1'b0, 0, got);
    do_req("b2g_57",  1'b0, 8'h57, 8'h25, 1'b0, 0, got);
    do_req("b2g_99",  1'b0, 8'h99, 8'h52, 1'b0, 1, got);
    do_req("b2g_00",  1'b0, 8'h00, 8'h00, 1'b0, 0, got);
    do_req("e_b2g5A", 1'b0, 8'h5A, 8'h00, 1'b1, 0, got);
    do_req("e_g2b44", 1'b1, 8'h44, 8'h99, 1'b1, 2, got);
    do_req("e_g2b80", 1'b1, 8'h80, 8'h99, 1'b1, 0, got);

    // Backpressure with a competing request held on the input side.
    send("bp", 1'b1, 8'h25);
    wait_out("bp");
    bus.in_valid = 1'b1;
    bus.in_mode  = 1'b0;
    bus.in_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp:data_hold",  32'(bus.out_data),  32'h57);
      check("bp:valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp:no_ready",   32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    take("bp");
    @(negedge clk);
    check("bp:single_xfer", 32'(bus.out_valid), 32'd0);

    // Reset three cycles into a conversion.
    send("mid_rst", 1'b1, 8'h25);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst:in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst:out_data",  32'(bus.out_data),  32'd0);
    check("mid_rst:out_err",   32'(bus.out_err),   32'd0);
    stale = 1'b0;
    repeat (15) begin
      @(negedge clk);
      stale = stale | bus.out_valid;
    end
    check("mid_rst:no_stale", 32'(stale), 32'd0);
    do_req("post_rst", 1'b0, 8'h42, 8'h3F, 1'b0, 0, got);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      md = 1'($urandom);
      if ($urandom_range(0, 1) == 0)
        d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        d = 8'($urandom);
      model(md, d, ed, ee);
      do_req("rand", md, d, ed, ee, $urandom_range(0, 3), got);
    end

    // Exhaustive BCD -> Gray -> BCD round trip.
    for (int v = 0; v < 100; v++) begin
      bcd = 8'(((v / 10) << 4) | (v % 10));
      model(1'b0, bcd, ed, ee);
      do_req("rt_fwd", 1'b0, bcd, ed, ee, 0, got);
      model(1'b1, got, ed, ee);
      do_req("rt_back", 1'b1, got, ed, ee, 0, got2);
      check("rt:value", 32'(got2), 32'(bcd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gray_bcd_conv_seq.md
# gray_bcd_conv_seq

Parametrised, iterative, handshaked converter between packed multi-digit BCD and Gray-coded binary. It is the successor of the team's single-digit combinational BCD/Gray converter, generalised to `DIGITS` decimal digits. It runs both directions with one shift/add-3 datapath, double-dabble for Gray→BCD and reverse double-dabble for BCD→Gray. It sits between the decimal display/entry path and the Gray-coded counter/encoder path, with valid/ready on both sides.

## Interface
- `DIGITS`, default 2: number of BCD digits. Data width `DW = 4*DIGITS`.
- `BIN_W`, default 7: binary/Gray width.
  - Legal only if 2^BIN_W > 10^DIGITS − 1 and BIN_W ≤ DW.
  - An illegal combination is an elaboration error.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block can accept; high only in IDLE.
- `in_mode` input 1: 0 = BCD→Gray, 1 = Gray→BCD; sampled at accept.
- `in_data` input DW: packed BCD (digit 0 in [3:0]) or Gray value in [BIN_W-1:0].
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts.
- `out_data` output DW: packed BCD, or Gray zero-extended to DW.
- `out_err` output 1: input invalid or out of range; qualified by `out_valid`.

## Operation
- Accept = `in_valid && in_ready` at a rising edge. Accept latches `in_mode`, loads the datapath and clears the iteration counter.
- States: IDLE → CONV → DONE → IDLE.
  - IDLE: `in_ready`=1. Accept → CONV.
  - CONV: exactly BIN_W iterations, one per cycle. The last iteration → DONE.
  - DONE: `out_valid`=1. `out_valid && out_ready` → IDLE.
- Mode 1 (Gray→BCD):
  - At accept, Gray is converted to binary by prefix-XOR from the MSB.
  - Error if `in_data[DW-1:BIN_W]` ≠ 0, or if the binary value > 10^DIGITS − 1.
  - CONV runs double-dabble: each iteration first adds 3 to every BCD digit ≥ 5, then shifts left 1, taking in the binary MSB.
- Mode 0 (BCD→Gray):
  - Error if any input digit > 9 (checked at accept).
  - CONV runs reverse double-dabble: each iteration shifts right 1 (BCD LSB goes into the binary MSB), then subtracts 3 from every digit ≥ 8.
  - Result is binary ^ (binary >> 1), formed when loading `out_data`.
- Error result:
  - Mode 1: `out_data` = all digits 9, `out_err`=1.
  - Mode 0: `out_data` = 0, `out_err`=1.
  - CONV still runs its full BIN_W cycles, so latency does not depend on the data.
- `out_data`/`out_err` are registered. They load on entry to DONE and stay stable until the handshake completes.
- No accept while in CONV or DONE. A new request is accepted no earlier than the cycle after the output handshake.
- Reset in any state, including mid-CONV or DONE with stalled `out_ready`:
  - Next state IDLE; any pending conversion is discarded.
  - `out_valid`=0, `out_data`=0, `out_err`=0, `in_ready`=1 from the cycle after the reset edge.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_err`=0, state IDLE, counter 0.
- Accept at edge k: CONV iterations occur on edges k+1 … k+BIN_W. `out_valid` rises after edge k+BIN_W, giving latency BIN_W cycles (7 at default).
- Output handshake at edge m: `out_valid` falls and `in_ready` rises after edge m. The next accept is possible at edge m+1.
- Peak throughput is one conversion per BIN_W+2 cycles.
- `in_valid` held high while `in_ready`=0 has no effect. `in_data`/`in_mode` are don't-care except at accept.
- `out_ready` held low keeps DONE indefinitely, with outputs unchanged.

## Test plan
All scenarios use DIGITS=2, BIN_W=7.
- Mode 1, `in_data`=8'h25 (Gray of 57) → `out_data`=8'h57, `out_err`=0; `out_valid` rises exactly 7 cycles after accept.
- Mode 0, `in_data`=8'h57 → `out_data`=8'h25. Mode 0, 8'h99 → 8'h52. Mode 0, 8'h00 → 8'h00. All with `out_err`=0.
- Errors:
  - Mode 0, 8'h5A → `out_data`=8'h00, `out_err`=1.
  - Mode 1, 8'h44 (Gray of 120) → 8'h99, `out_err`=1.
  - Mode 1, 8'h80 → 8'h99, `out_err`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `out_data` stable, `in_ready`=0, a held `in_valid` is ignored. Release → exactly one transfer, `in_ready`=1 the next cycle.
- Reset mid-CONV (cycle 3 after accept) → next cycle `in_ready`=1, `out_valid`=0; no stale result ever appears. A fresh request then converts correctly.
- Exhaustive round-trip: for all 100 BCD values, mode 0 then mode 1 on the result → original value, `out_err`=0.
